// File: rtl/mm_pkg.sv
// Shared types and constants for the FP32 matrix loader.
// Header field positions, FP32 exponent fields and the loader FSM states.
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    START,
    WAIT_DONE
  } state_t;

  localparam int HDR_M_LSB = 16;
  localparam int HDR_K_LSB = 8;
  localparam int HDR_N_LSB = 0;
  localparam int HDR_DW    = 8;

  localparam int          FP_EXP_MSB = 30;
  localparam int          FP_EXP_LSB = 23;
  localparam logic [7:0]  FP_EXP_INF = 8'hFF;

  typedef struct packed {
    logic [HDR_DW-1:0] m;
    logic [HDR_DW-1:0] k;
    logic [HDR_DW-1:0] n;
  } dims_t;

  function automatic dims_t hdr_dims(input logic [31:0] w);
    dims_t d;
    d.m = w[HDR_M_LSB +: HDR_DW];
    d.k = w[HDR_K_LSB +: HDR_DW];
    d.n = w[HDR_N_LSB +: HDR_DW];
    return d;
  endfunction

endpackage

// File: rtl/mm_hdr_check.sv
// Combinational header validation against the maximum dimensions.
// Also returns the M*K and K*N element counts for the load phases.
module mm_hdr_check
  import mm_pkg::*;
#(
  parameter int MAX_M = 100,
  parameter int MAX_K = 100,
  parameter int MAX_N = 100,
  parameter int PW    = 15
) (
  input  logic [31:0]   hdr,
  output logic          ok,
  output logic [PW-1:0] mk,
  output logic [PW-1:0] kn
);

  localparam logic [HDR_DW-1:0] LIM_M = HDR_DW'(MAX_M);
  localparam logic [HDR_DW-1:0] LIM_K = HDR_DW'(MAX_K);
  localparam logic [HDR_DW-1:0] LIM_N = HDR_DW'(MAX_N);

  dims_t d;

  assign d  = hdr_dims(hdr);
  assign ok = (d.m != '0) && (d.m <= LIM_M) &&
              (d.k != '0) && (d.k <= LIM_K) &&
              (d.n != '0) && (d.n <= LIM_N);
  assign mk = PW'(d.m) * PW'(d.k);
  assign kn = PW'(d.k) * PW'(d.n);

endmodule

// File: rtl/fp32_matrix_loader.sv
// Stream feeder for the FP32 matmul engine: header, A, B, start, wait.
// Define LOADER_NONFINITE_CHECK_EN to add the nonfinite_seen flag.
module fp32_matrix_loader
  import mm_pkg::*;
#(
  parameter int MAX_M = 100,
  parameter int MAX_K = 100,
  parameter int MAX_N = 100,
  parameter int A_AW  = $clog2(MAX_M*MAX_K),
  parameter int B_AW  = $clog2(MAX_K*MAX_N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [31:0]     s_data,
  output logic            a_we,
  output logic [A_AW-1:0] a_addr,
  output logic [31:0]     a_wdata,
  output logic            b_we,
  output logic [B_AW-1:0] b_addr,
  output logic [31:0]     b_wdata,
  output logic [7:0]      M_val,
  output logic [7:0]      K_val,
  output logic [7:0]      N_val,
  output logic            start,
  input  logic            engine_done,
  output logic            busy,
  output logic            hdr_err
`ifdef LOADER_NONFINITE_CHECK_EN
  ,
  output logic            nonfinite_seen
`endif
);

  localparam int CW = ((A_AW > B_AW) ? A_AW : B_AW) + 1;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] mk_r;
  logic [CW-1:0] kn_r;
  logic [CW-1:0] mk;
  logic [CW-1:0] kn;
  logic          hdr_ok;
  logic          acc;
  dims_t         d;

  assign acc    = s_valid && s_ready;
  assign cnt_nx = cnt + CW'(1);
  assign d      = hdr_dims(s_data);

  mm_hdr_check #(
    .MAX_M (MAX_M),
    .MAX_K (MAX_K),
    .MAX_N (MAX_N),
    .PW    (CW)
  ) u_hdr (
    .hdr (s_data),
    .ok  (hdr_ok),
    .mk  (mk),
    .kn  (kn)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      s_ready <= 1'b0;
      busy    <= 1'b0;
      start   <= 1'b0;
      hdr_err <= 1'b0;
      a_we    <= 1'b0;
      a_addr  <= '0;
      a_wdata <= '0;
      b_we    <= 1'b0;
      b_addr  <= '0;
      b_wdata <= '0;
      M_val   <= '0;
      K_val   <= '0;
      N_val   <= '0;
      cnt     <= '0;
      mk_r    <= '0;
      kn_r    <= '0;
    end else begin
      a_we  <= 1'b0;
      b_we  <= 1'b0;
      start <= 1'b0;
      unique case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (acc) begin
            if (hdr_ok) begin
              M_val   <= d.m;
              K_val   <= d.k;
              N_val   <= d.n;
              mk_r    <= mk;
              kn_r    <= kn;
              hdr_err <= 1'b0;
              busy    <= 1'b1;
              cnt     <= '0;
              state   <= LOAD_A;
            end else begin
              hdr_err <= 1'b1;
            end
          end
        end
        LOAD_A: begin
          if (acc) begin
            a_we    <= 1'b1;
            a_addr  <= cnt[A_AW-1:0];
            a_wdata <= s_data;
            if (cnt_nx == mk_r) begin
              cnt   <= '0;
              state <= LOAD_B;
            end else begin
              cnt <= cnt_nx;
            end
          end
        end
        LOAD_B: begin
          if (acc) begin
            b_we    <= 1'b1;
            b_addr  <= cnt[B_AW-1:0];
            b_wdata <= s_data;
            if (cnt_nx == kn_r) begin
              cnt     <= '0;
              s_ready <= 1'b0;
              state   <= START;
            end else begin
              cnt <= cnt_nx;
            end
          end
        end
        START: begin
          start <= 1'b1;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (engine_done) begin
            busy    <= 1'b0;
            s_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LOADER_NONFINITE_CHECK_EN
  logic elem_acc;

  assign elem_acc = acc && ((state == LOAD_A) || (state == LOAD_B));

  always_ff @(posedge clk) begin
    if (rst) begin
      nonfinite_seen <= 1'b0;
    end else if (acc && (state == IDLE) && hdr_ok) begin
      nonfinite_seen <= 1'b0;
    end else if (elem_acc &&
                 (s_data[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_INF)) begin
      nonfinite_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fp32_matrix_loader.sv
// Directed bench for fp32_matrix_loader with a write scoreboard.
// Expected A/B writes are queued when beats are driven, popped on a_we/b_we.
module tb_fp32_matrix_loader;

  localparam int A_AW = 14;
  localparam int B_AW = 14;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [31:0]     s_data = '0;
  logic            a_we;
  logic [A_AW-1:0] a_addr;
  logic [31:0]     a_wdata;
  logic            b_we;
  logic [B_AW-1:0] b_addr;
  logic [31:0]     b_wdata;
  logic [7:0]      M_val;
  logic [7:0]      K_val;
  logic [7:0]      N_val;
  logic            start;
  logic            engine_done = 1'b0;
  logic            busy;
  logic            hdr_err;
`ifdef LOADER_NONFINITE_CHECK_EN
  logic            nonfinite_seen;
`endif

  fp32_matrix_loader dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .M_val       (M_val),
    .K_val       (K_val),
    .N_val       (N_val),
    .start       (start),
    .engine_done (engine_done),
    .busy        (busy),
    .hdr_err     (hdr_err)
`ifdef LOADER_NONFINITE_CHECK_EN
    ,
    .nonfinite_seen (nonfinite_seen)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    bit          last;
  } wr_t;

  wr_t qa[$];
  wr_t qb[$];
  int  errors = 0;
  int  checks = 0;
  bit  pa = 1'b0;
  bit  pb = 1'b0;
  bit  start_next = 1'b0;
  int  ia = 0;
  int  ib = 0;
  int  cm = 0;
  int  ck = 0;
  int  cn = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit  exp_start;
    wr_t e;
    @(posedge clk);
    #1;
    exp_start  = start_next;
    start_next = 1'b0;
    chk("a_we", {31'd0, a_we}, {31'd0, pa});
    if (a_we === 1'b1 && qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_addr", 32'(a_addr), e.addr);
      chk("a_wdata", a_wdata, e.data);
    end
    chk("b_we", {31'd0, b_we}, {31'd0, pb});
    if (b_we === 1'b1 && qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_addr", 32'(b_addr), e.addr);
      chk("b_wdata", b_wdata, e.data);
      if (e.last) start_next = 1'b1;
    end
    chk("start", {31'd0, start}, {31'd0, exp_start});
    pa = 1'b0;
    pb = 1'b0;
  endtask

  // kind: 0 header, 1 A element, 2 B element
  task automatic send(input logic [31:0] w, input int kind);
    int m;
    int k;
    int n;
    s_valid = 1'b1;
    s_data  = w;
    if (kind == 0 && s_ready === 1'b1) begin
      m = int'(w[23:16]);
      k = int'(w[15:8]);
      n = int'(w[7:0]);
      if (m >= 1 && m <= 100 && k >= 1 && k <= 100 &&
          n >= 1 && n <= 100) begin
        cm = m;
        ck = k;
        cn = n;
        ia = 0;
        ib = 0;
      end
    end else if (kind == 1) begin
      chk("s_ready_a", {31'd0, s_ready}, 32'd1);
      if (s_ready === 1'b1) begin
        qa.push_back('{ia, w, 1'b0});
        pa = 1'b1;
        ia++;
      end
    end else if (kind == 2) begin
      chk("s_ready_b", {31'd0, s_ready}, 32'd1);
      if (s_ready === 1'b1) begin
        qb.push_back('{ib, w, (ib == ck*cn-1)});
        pb = 1'b1;
        ib++;
      end
    end
    tick();
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic load_all(input int m, input int k, input int n);
    for (int i = 0; i < m*k; i++) send(32'h3F80_0000 + 32'(i), 1);
    for (int i = 0; i < k*n; i++) send(32'h4000_0000 + 32'(i), 2);
  endtask

  task automatic done_pulse();
    engine_done = 1'b1;
    tick();
    engine_done = 1'b0;
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("ready_after_done", {31'd0, s_ready}, 32'd1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_start"}, {31'd0, start}, 32'd0);
    chk({tag, "_a_we"}, {31'd0, a_we}, 32'd0);
    chk({tag, "_b_we"}, {31'd0, b_we}, 32'd0);
    chk({tag, "_hdr_err"}, {31'd0, hdr_err}, 32'd0);
    chk({tag, "_mkn"}, {8'd0, M_val, K_val, N_val}, 32'd0);
    chk({tag, "_a_addr"}, 32'(a_addr), 32'd0);
    chk({tag, "_b_addr"}, 32'(b_addr), 32'd0);
    chk({tag, "_a_wdata"}, a_wdata, 32'd0);
    chk({tag, "_b_wdata"}, b_wdata, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    rst = 1'b0;
    idle(1);
    chk("idle_ready", {31'd0, s_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // 2x3x2 back-to-back job
    send(32'h0002_0302, 0);
    chk("j1_busy", {31'd0, busy}, 32'd1);
    chk("j1_mkn", {8'd0, M_val, K_val, N_val}, 32'h0002_0302);
    chk("j1_hdr_err", {31'd0, hdr_err}, 32'd0);
    load_all(2, 3, 2);
    idle(1);
    chk("j1_ready_start", {31'd0, s_ready}, 32'd0);
    idle(2);
    chk("j1_busy_wait", {31'd0, busy}, 32'd1);
    done_pulse();

    // rejected header keeps dims, next valid header clears error
    send(32'h0002_0002, 0);
    chk("bad_hdr_err", {31'd0, hdr_err}, 32'd1);
    chk("bad_busy", {31'd0, busy}, 32'd0);
    chk("bad_mkn", {8'd0, M_val, K_val, N_val}, {8'd0, 8'(cm), 8'(ck), 8'(cn)});
    idle(1);
    chk("bad_ready", {31'd0, s_ready}, 32'd1);
    send(32'h0001_0101, 0);
    chk("ok_hdr_err", {31'd0, hdr_err}, 32'd0);
    chk("ok_busy", {31'd0, busy}, 32'd1);
    chk("ok_mkn", {8'd0, M_val, K_val, N_val}, 32'h0001_0101);

    // 1x1x1 with bubbles between beats
    idle(1);
    send(32'h3F80_0000, 1);
    idle(1);
    send(32'h4040_0000, 2);
    idle(1);

    // long wait with s_valid held high
    s_valid = 1'b1;
    s_data  = 32'h0001_0101;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("wait_ready", {31'd0, s_ready}, 32'd0);
    end
    done_pulse();
    send(32'h0001_0101, 0);
    chk("after_wait_busy", {31'd0, busy}, 32'd1);
    load_all(1, 1, 1);
    idle(1);
    done_pulse();

    // reset in the middle of LOAD_A
    send(32'h0002_0302, 0);
    for (int i = 0; i < 3; i++) send(32'h3F80_0000 + 32'(i), 1);
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = 32'h3F80_0003;
    tick();
    chk_reset_outs("midrst");
    rst = 1'b0;
    idle(6);
    send(32'h0002_0302, 0);
    load_all(2, 3, 2);
    idle(2);
    done_pulse();

`ifdef LOADER_NONFINITE_CHECK_EN
    send(32'h0001_0101, 0);
    chk("nf_clear0", {31'd0, nonfinite_seen}, 32'd0);
    send(32'h7FC0_0000, 1);
    chk("nf_set", {31'd0, nonfinite_seen}, 32'd1);
    send(32'h3F80_0000, 2);
    idle(1);
    done_pulse();
    chk("nf_sticky", {31'd0, nonfinite_seen}, 32'd1);
    send(32'h0001_0101, 0);
    chk("nf_cleared", {31'd0, nonfinite_seen}, 32'd0);
    load_all(1, 1, 1);
    idle(1);
    done_pulse();
`endif

    chk("qa_empty", 32'(qa.size()), 32'd0);
    chk("qb_empty", 32'(qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
